// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter granting one of eight sources ownership of a shared 8:1 mux.
// Define MUX8_ARB_TIMEOUT_EN to revoke grants that are held for TIMEOUT cycles.
module mux8_rr_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_reg;
  logic [2:0] ptr_reg;
  logic [2:0] sel_reg;
  logic [7:0] grant_reg;
  logic       busy_reg;

  logic [2:0] winner;
  logic [7:0] winner_onehot;
  logic       release_req;
  logic       expire;

  // First requesting source at or after the pointer, wrapping modulo 8.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_reg + 3'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
    assign winner_onehot[gi] = (winner == 3'(gi));
  end

  assign release_req = done | ~req[sel_reg];

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_reg;
  logic       timeout_reg;

  // Counter is zero on the first grant cycle, so expiry fires after TIMEOUT cycles.
  assign expire = (state_reg == GRANT) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= expire & ~release_req;
      if (state_reg == GRANT) begin
        cnt_reg <= cnt_reg + 8'd1;
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign timeout = timeout_reg;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0);
  assign expire     = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      sel_reg   <= '0;
      busy_reg  <= 1'b0;
      ptr_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            state_reg <= GRANT;
            grant_reg <= winner_onehot;
            sel_reg   <= winner;
            busy_reg  <= 1'b1;
          end
        end
        GRANT: begin
          // Released owner drops to lowest priority for the next arbitration.
          if (release_req || expire) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            ptr_reg   <= sel_reg + 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant = grant_reg;
  assign sel   = sel_reg;
  assign busy  = busy_reg;

endmodule

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum grant length in cycles when timeout support is compiled in (legal range 2..256).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: req  input  8  request vector, bit i = source i wants the shared 8:1 mux.
REQ-006 Port: done  input  1  current owner releases the mux this cycle.
REQ-007 Port: grant  output  8  one-hot grant, registered, all-zero when no owner.
REQ-008 Port: sel  output  3  registered mux select, equals index of the granted bit.
REQ-009 Port: busy  output  1  high while a grant is active.
REQ-010 Port: timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-011 Two states: IDLE and GRANT.
REQ-012 Internal round-robin pointer ptr (3 bits) names the highest-priority source.
REQ-013 IDLE with req != 0: pick the first set bit scanning ptr, ptr+1, ... ptr+7 mod 8; next cycle grant = one-hot of winner, sel = winner, busy = 1, state GRANT.
REQ-014 IDLE with req == 0: grant = 0, busy = 0, sel holds its last value, state stays IDLE.
REQ-015 Grant latency: request sampled at edge N, grant visible after edge N+1; no combinational path from req to grant.
REQ-016 GRANT: grant, sel and busy hold constant regardless of other req bits.
REQ-017 Release: in GRANT, done = 1 or req[sel] = 0 causes grant = 0, busy = 0, ptr = sel+1 mod 8 (7 wraps to 0), and return to IDLE at the next edge.
REQ-018 At least one IDLE cycle separates consecutive grants; a new winner is picked from the IDLE cycle's req.
REQ-019 done sampled while in IDLE is ignored.
REQ-020 A source that keeps req high after release is not re-granted before every other requesting source has been served once (fairness bound: 7 intervening grants).
REQ-021 grant is always zero or one-hot; busy == (grant != 0).

Reset
REQ-022 rst = 1 at an edge forces state IDLE, grant = 0, sel = 0, busy = 0, timeout = 0, ptr = 0, timeout counter = 0, including mid-grant.
REQ-023 The first post-reset arbitration gives source 0 highest priority.

Configuration
REQ-024 Macro MUX8_ARB_TIMEOUT_EN compiles in grant timeout.
REQ-025 With MUX8_ARB_TIMEOUT_EN: a counter clears on grant entry and increments each GRANT cycle; if TIMEOUT GRANT cycles elapse without release, the arbiter releases exactly as REQ-017 and pulses timeout = 1 for one cycle coincident with the IDLE cycle.
REQ-026 With MUX8_ARB_TIMEOUT_EN: done or req[sel] drop on the final counted cycle is a normal release; timeout stays 0.
REQ-027 Without MUX8_ARB_TIMEOUT_EN: no counter, timeout tied to 0, grants last until release.

Verification
REQ-028 After reset, req = 8'b0000_0001 -> one cycle later grant = 8'h01, sel = 0, busy = 1; done pulse -> next cycle grant = 0, busy = 0.
REQ-029 req = 8'hFF held, done pulsed each grant -> sel sequence 0,1,2,...,7,0 with one idle cycle between grants.
REQ-030 Grant to source 7 released, then req = 8'b1000_0001 -> grant goes to source 0 (pointer wrap).
REQ-031 Source 3 granted, req[3] drops with done = 0 -> released, next pointer 4; req = 8'b0001_1000 -> grant goes to source 4.
REQ-032 Source 5 granted, rst = 1 for one cycle -> grant = 0, sel = 0, busy = 0; req = 8'b0010_0001 afterwards -> grant to source 0.
REQ-033 With MUX8_ARB_TIMEOUT_EN, TIMEOUT = 4, req[2] held, done = 0 -> grant held 4 cycles, then grant = 0 and timeout = 1 for one cycle; without macro -> grant held indefinitely, timeout = 0.
